// File: rtl/dac_waveform_source.sv
// Waveform sample source feeding the DAC SPI driver: phase accumulator or LFSR
// produces one 12-bit sample pair per tick, with a valid/ack handshake and sticky overrun.
module dac_waveform_source #(
    parameter int TICK_DIV = 50000,
    parameter int PHASE_W  = 16
) (
    input  logic        CLK_50M,
    input  logic        RST,
    input  logic [3:0]  SW,
    input  logic [15:0] freq_word,
    input  logic        sample_ack,
    output logic [11:0] Va,
    output logic [11:0] Vb,
    output logic        sample_valid,
    output logic        overrun
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [3:0]         sw_meta_reg;
    logic [3:0]         sw_sync_reg;
    logic [2:0]         mode_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               tick;
    logic               hold;
    logic [PHASE_W-1:0] phase_reg;
    logic [31:0]        lfsr_reg;
    logic [31:0]        lfsr_next;
    logic               load_pending_reg;
    logic [11:0]        sample;
    logic               unused_bits;

    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            sw_meta_reg <= '0;
            sw_sync_reg <= '0;
        end else begin
            sw_meta_reg <= SW;
            sw_sync_reg <= sw_meta_reg;
        end
    end

    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            cnt_reg <= '0;
        end else if (tick) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign tick = (cnt_reg == CNT_W'(TICK_DIV - 1));
    // Hold is judged from the value being captured on this tick, so it acts at the same boundary as a mode change.
    assign hold = sw_sync_reg[3];

    // Left shift with feedback from taps 30 and 27; bit 31 only carries history.
    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_lfsr
            assign lfsr_next[gi] = lfsr_reg[gi-1];
        end
    endgenerate
    assign lfsr_next[0] = lfsr_reg[30] ^ lfsr_reg[27];
    assign unused_bits  = lfsr_reg[31];

    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            mode_reg         <= '0;
            phase_reg        <= '0;
            lfsr_reg         <= 32'd1;
            load_pending_reg <= 1'b0;
        end else begin
            load_pending_reg <= tick && !hold;
            if (tick) begin
                mode_reg <= sw_sync_reg[2:0];
                if (!hold) begin
                    phase_reg <= phase_reg + freq_word;
                    lfsr_reg  <= lfsr_next;
                end
            end
        end
    end

    always_comb begin
        sample = '0;
        case (mode_reg[1:0])
            2'b00:   sample = phase_reg[PHASE_W-1 -: 12];
            2'b01:   sample = phase_reg[PHASE_W-1] ? ~phase_reg[PHASE_W-2 -: 12]
                                                   :  phase_reg[PHASE_W-2 -: 12];
            2'b10:   sample = phase_reg[PHASE_W-1] ? 12'hFFF : 12'h000;
            default: sample = lfsr_reg[11:0];
        endcase
    end

    // A load always wins over a coincident ack; overrun only if the old sample was never taken.
    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            Va           <= '0;
            Vb           <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else if (load_pending_reg) begin
            Va           <= sample;
            Vb           <= mode_reg[2] ? ~sample : sample;
            sample_valid <= 1'b1;
            if (sample_valid && !sample_ack) begin
                overrun <= 1'b1;
            end
        end else if (sample_ack) begin
            sample_valid <= 1'b0;
        end
    end

endmodule

// File: doc/dac_waveform_source.md
# dac_waveform_source

Upstream sample source for the DAC SPI driver: produces 12-bit samples for DAC channels A and B at a programmable sample rate, from a phase accumulator (sawtooth, triangle, square) or a 32-bit LFSR (noise), selected by the board switches. Sits between the slide switches and the DAC driver's `Va`/`Vb` inputs. It also provides a valid/ack handshake so the driver consumes each sample exactly once, and it flags overruns.

## Interface
- `TICK_DIV`, 50000: CLK_50M cycles per sample tick (50000 gives a 1 kHz sample rate); must be ≥ 2.
- `PHASE_W`, 16: phase accumulator width; fixed at 16 in this revision.

- `CLK_50M` in 1: system clock, 50 MHz.
- `RST` in 1: synchronous, active-high reset.
- `SW` in 4: board slide switches, asynchronous.
  - `SW[1:0]` selects the mode: 00 saw, 01 triangle, 10 square, 11 noise.
  - `SW[2]` = channel B inverted.
  - `SW[3]` = hold.
- `freq_word` in 16: phase increment per tick; quasi-static.
- `sample_ack` in 1: one-cycle pulse from the DAC driver when a sample has been taken.
- `Va` out 12: channel A sample.
- `Vb` out 12: channel B sample.
- `sample_valid` out 1: a new, unconsumed sample is present on `Va`/`Vb`.
- `overrun` out 1: sticky flag; a sample was replaced before being acknowledged.

## Operation
- **Switch synchronizer:** `SW` passes through a 2-flop synchronizer. A mode register captures the synchronized value only on tick cycles, so a mode change takes effect at a sample boundary.
- **Tick counter:** counts 0..TICK_DIV-1. `tick` is high in the cycle where the count equals TICK_DIV-1; the counter wraps to 0 on the next edge.
- **On a tick edge with hold = 0:**
  - `phase <= phase + freq_word`, mod 2^16.
  - LFSR shifts left with `lfsr[0] <= lfsr[30] ^ lfsr[27]`.
  - The LFSR advances in every mode, so noise remains reproducible across mode switches.
- **On a tick edge with hold = 1:** phase and LFSR are frozen, and no new sample is produced. The tick counter keeps running.
- **Sample computation** (registered one cycle after the tick edge, from the updated phase/LFSR):
  - Saw: `phase[15:4]`.
  - Triangle: if `phase[15]` = 0 then `phase[14:3]`, else `~phase[14:3]`.
  - Square: `phase[15]` ? 12'hFFF : 12'h000.
  - Noise: `lfsr[11:0]`.
- **Channel outputs:** `Va` = computed sample. `Vb` = `4095 − Va` when `SW[2]`, else `Vb` = `Va`. Both update on the same edge.
- **Handshake:**
  - `sample_valid` rises on the edge `Va`/`Vb` load.
  - It clears on the edge after `sample_ack` is sampled high.
  - `sample_ack` while `sample_valid` = 0 is ignored.
- **Overrun:** a load while `sample_valid` = 1 and `sample_ack` = 0 overwrites the sample, keeps valid = 1, and sets `overrun`.
- **Load and ack in the same cycle:** the new sample wins, valid stays 1, and no overrun is flagged.
- **Clearing overrun:** only `RST` clears it.

## Timing
- **Reset values:**
  - tick counter 0, phase 0, LFSR 32'd1, mode register 0 (saw).
  - `Va`, `Vb`: 0.
  - `sample_valid`, `overrun`: 0.
- **Reset priority:** reset asserted mid-operation overrides everything on that edge, including a coincident tick or ack.
- **First sample:** counting edges from the first one with `RST` low:
  - edge TICK_DIV: phase/LFSR update;
  - edge TICK_DIV+1: `Va`/`Vb` load and `sample_valid` = 1.
- **Steady state:** one sample every TICK_DIV cycles. Tick-to-output latency is 1 cycle.
- **Switch latency:** a switch change reaches the mode register at the first tick at least 2 cycles after the change.
- **Phase wrap:** phase wraps silently from 0xFFFF to 0x0000 with no special case. `freq_word` = 0 gives a constant output, but samples still strobe valid.
- **Ack to valid low:** 1 cycle.
- **Driver timing assumption:** the DAC driver must ack within TICK_DIV−1 cycles to avoid overrun.

## Test plan
All scenarios use TICK_DIV = 4.

- **Reset.** Hold `RST` for 3 cycles, then release. All outputs are 0 during and after reset. `sample_valid` first rises at edge 5 after release.
- **Saw.** Mode 00, `freq_word` = 0x1000, ack every sample. `Va` = 0x100, 0x200, …, 0xF00, then 0x000 on the 16th sample (wrap). `Vb` = `Va`. `overrun` stays 0.
- **Triangle and inversion.** Mode 01, `SW[2]` = 1, `freq_word` = 0x1000. Samples:
  - phase 0x1000: `Va` = 0x200, `Vb` = 0xDFF.
  - phase 0x8000: `Va` = 0xFFF, `Vb` = 0x000.
  - phase 0xC000: `Va` = 0x7FF.
- **Noise and hold.** Mode 11, from reset. Successive `Va` = 0x002, 0x004, 0x008, …. Then set `SW[3]` = 1: `Va` freezes and `sample_valid` does not reassert after ack. Clearing hold resumes the sequence where it stopped.
- **Handshake edge cases.**
  - Never ack: after the second sample, `overrun` = 1 and stays 1 after later acks.
  - Ack in the same cycle as a load: `sample_valid` stays 1 and `overrun` is not set.
  - Ack while `sample_valid` = 0: no effect.
- **Reset mid-stream.** Assert `RST` on the same cycle as a tick with mode 10. `phase`, `Va`, `sample_valid` and `overrun` all return to 0, and the first-sample timing repeats exactly.
